// File: rtl/spi_master_if.sv
// Request/response handshake and SPI pin bundle between spi_master and its surroundings.
// The master modport is the spi_master's view; the slave modport is the requester/pin side.
interface spi_master_if;
    logic       data_in_valid;
    logic [7:0] data_in;
    logic       busy;
    logic       data_out_valid;
    logic [7:0] data_out;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  data_in_valid, data_in, miso,
        output busy, data_out_valid, data_out, sck, cs, mosi
    );

    modport slave (
        output data_in_valid, data_in, miso,
        input  busy, data_out_valid, data_out, sck, cs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0, MSB-first, 8-bit master with valid/busy request side and a 2-flop miso synchronizer.
// Optional SPI_MASTER_BURST_EN: one-entry pending byte chains transfers inside a single cs frame.
module spi_master #(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned CS_IDLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus_io
);

    localparam int unsigned CNT_MAX = (CLK_DIV > CS_IDLE_CYCLES) ? CLK_DIV : CS_IDLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(CS_IDLE_CYCLES - 1);

    // S_LAST is the sck-low half of bit 0's pair; mosi is left unchanged there.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LAST  = 3'd4,
        S_HOLD  = 3'd5,
        S_GAP   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             dov_q, dov_d;
    logic [7:0]       dout_q, dout_d;
    logic             miso_meta_q, miso_sync_q;
    logic             phase_end_c;

`ifdef SPI_MASTER_BURST_EN
    logic [7:0]       pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             pend_window_c;
`endif

    assign phase_end_c = (cnt_q == '0);

`ifdef SPI_MASTER_BURST_EN
    // Capture is closed from the bit-0 decision edge onward so a late byte cannot be stranded.
    assign pend_window_c = (state_q == S_SETUP) || (state_q == S_LOW) ||
                           ((state_q == S_HIGH) && !(phase_end_c && (bit_q == 3'd0)));
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = phase_end_c ? cnt_q : (cnt_q - CNT_W'(1));
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        dov_d   = 1'b0;
        dout_d  = dout_q;
`ifdef SPI_MASTER_BURST_EN
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus_io.data_in_valid) begin
                    tx_d    = bus_io.data_in;
                    mosi_d  = bus_io.data_in[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 3'd7;
                    cnt_d   = PHASE_LOAD;
                    state_d = S_SETUP;
                end
            end

            S_SETUP, S_LOW: begin
                if (phase_end_c) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], miso_sync_q};
                    cnt_d   = PHASE_LOAD;
                    state_d = S_HIGH;
                end
            end

            S_HIGH: begin
                if (phase_end_c) begin
                    sck_d = 1'b0;
                    cnt_d = PHASE_LOAD;
                    if (bit_q != 3'd0) begin
                        bit_d   = bit_q - 3'd1;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                        state_d = S_LOW;
                    end else begin
                        state_d = S_LAST;
`ifdef SPI_MASTER_BURST_EN
                        // Chain the pending byte: this low phase doubles as its setup phase.
                        if (pend_full_q) begin
                            pend_full_d = 1'b0;
                            tx_d        = pend_q;
                            mosi_d      = pend_q[7];
                            bit_d       = 3'd7;
                            dout_d      = rx_q;
                            dov_d       = 1'b1;
                            state_d     = S_SETUP;
                        end
`endif
                    end
                end
            end

            S_LAST: begin
                if (phase_end_c) begin
                    cnt_d   = PHASE_LOAD;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (phase_end_c) begin
                    cs_d    = 1'b1;
                    dout_d  = rx_q;
                    dov_d   = 1'b1;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (phase_end_c) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SPI_MASTER_BURST_EN
        if (bus_io.data_in_valid && !pend_full_q && pend_window_c) begin
            pend_d      = bus_io.data_in;
            pend_full_d = 1'b1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            dov_q   <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            dov_q   <= dov_d;
            dout_q  <= dout_d;
        end
    end

    // miso arrives from another clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= bus_io.miso;
            miso_sync_q <= miso_meta_q;
        end
    end

`ifdef SPI_MASTER_BURST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 8'h00;
            pend_full_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end
`endif

    assign bus_io.sck            = sck_q;
    assign bus_io.cs             = cs_q;
    assign bus_io.mosi           = mosi_q;
    assign bus_io.busy           = busy_q;
    assign bus_io.data_out_valid = dov_q;
    assign bus_io.data_out       = dout_q;

endmodule
